dds_sweep_ctrl: RTL
===================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 16, width of the dwell counter and the dwell input.
REQ-002 SHALL have port clk  input  1  single clock; all registers update on its rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a sweep, sampled each rising edge.
REQ-005 SHALL have port abort  input  1  stop the sweep, sampled each rising edge.
REQ-006 SHALL have port mode  input  1  0 = single sweep, 1 = continuous triangle sweep.
REQ-007 SHALL have ports f_start, f_stop, f_step  input  8 each  unsigned sweep endpoints and step magnitude.
REQ-008 SHALL have port dwell  input  DWELL_W  number of extra cycles each phinc value is held.
REQ-009 SHALL have port phinc  output  8  phase increment driven to the phase accumulator.
REQ-010 SHALL have port acc_clrn  output  1  active-low re-phase pulse to the accumulator clear.
REQ-011 SHALL have port busy  output  1  high while the sweep is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at single-sweep completion.

Function
REQ-013 SHALL implement states IDLE and SWEEP; the sweep direction (up/down) and the current target SHALL be held in registers.
REQ-014 In IDLE, start=1 and abort=0 SHALL latch f_start, f_stop, step, dwell and mode, load phinc with f_start and the dwell counter with dwell, and enter SWEEP on the same edge.
REQ-015 On that start edge, direction SHALL be up if f_stop >= f_start, else down, and the target SHALL be f_stop.
REQ-016 acc_clrn SHALL be 0 for exactly the one cycle following start acceptance, and 1 otherwise.
REQ-017 f_step = 0 SHALL be treated as step 1.
REQ-018 Inputs changing during SWEEP SHALL have no effect; only the latched copies SHALL be used.
REQ-019 In SWEEP, each phinc value SHALL be held for dwell+1 cycles; the dwell counter SHALL decrement each cycle and reload on reaching 0.
REQ-020 When the dwell counter is 0 and phinc is not equal to the target, phinc SHALL become phinc+step (up) or phinc-step (down).
REQ-021 The step result SHALL be computed in 9 bits and clamped to the target if it passes the target or wraps beyond 0 or 255; phinc SHALL never overshoot.
REQ-022 When the dwell counter is 0 and phinc equals the target in single mode, the block SHALL enter IDLE, pulse done for one cycle, and hold phinc at the target.
REQ-023 When the dwell counter is 0 and phinc equals the target in triangle mode, the block SHALL reverse direction and swap the target between the latched f_start and f_stop.
REQ-024 After a triangle reversal, stepping SHALL continue at the next dwell expiry; the endpoint value SHALL be held for exactly one dwell period, not two.
REQ-025 If f_start equals f_stop, single mode SHALL finish after one dwell period, and triangle mode SHALL hold phinc constant indefinitely.
REQ-026 abort=1 in SWEEP SHALL enter IDLE on that edge with phinc held at its current value and no done pulse.
REQ-027 abort SHALL take priority over start and over completion in the same cycle.
REQ-028 start asserted while in SWEEP SHALL be ignored.
REQ-029 busy SHALL equal 1 exactly while the state is SWEEP.
REQ-030 phinc SHALL change only on the start edge or at a dwell expiry.

Reset
REQ-031 While clr=1, the block SHALL force: state IDLE, phinc=0, dwell counter=0, direction up, busy=0, done=0, acc_clrn=1.
REQ-032 Assertion of clr SHALL take effect immediately, independent of clk.
REQ-033 Assertion of clr mid-sweep SHALL abandon the sweep with no done pulse.
REQ-034 After clr deasserts, the block SHALL wait in IDLE for a new start.

Verification
REQ-035 Single up sweep: f_start=10, f_stop=16, step=3, dwell=1, mode=0 -> phinc 10,10,13,13,16,16; done pulses on the next cycle; busy=0 afterwards; phinc stays 16.
REQ-036 Clamp: f_start=10, f_stop=16, step=4, dwell=0 -> phinc 10,14,16, then done; no value above 16 appears.
REQ-037 Down sweep with wrap guard: f_start=5, f_stop=0, step=4, dwell=0 -> phinc 5,1,0, then done; no 253 appears.
REQ-038 Triangle: f_start=2, f_stop=6, step=2, dwell=0, mode=1 -> phinc 2,4,6,4,2,4,6 ... repeating; done never asserts; busy stays 1.
REQ-039 Abort and priority: abort asserted mid-sweep at phinc=13 -> IDLE next edge, phinc=13, done=0; start and abort asserted together in IDLE -> remains IDLE.
REQ-040 Reset and start handling: clr pulsed asynchronously mid-sweep -> phinc=0, busy=0 immediately; a start pulse while busy is ignored; acc_clrn is low for exactly one cycle after each accepted start.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep controller for a DDS phase accumulator: steps phinc between two
// endpoints with a programmable dwell, either once or as a continuous triangle.
module dds_sweep_ctrl #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic               abort,
   input  logic               mode,
   input  logic [7:0]         f_start,
   input  logic [7:0]         f_stop,
   input  logic [7:0]         f_step,
   input  logic [DWELL_W-1:0] dwell,
   output logic [7:0]         phinc,
   output logic               acc_clrn,
   output logic               busy,
   output logic               done
);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t             state, state_nx;
   logic [7:0]         phinc_nx;
   logic [7:0]         target, target_nx;
   logic               dir_up, dir_up_nx;
   logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nx;
   logic [7:0]         lat_start, lat_start_nx;
   logic [7:0]         lat_stop, lat_stop_nx;
   logic [7:0]         lat_step, lat_step_nx;
   logic [DWELL_W-1:0] lat_dwell, lat_dwell_nx;
   logic               lat_mode, lat_mode_nx;
   logic               done_nx, acc_clrn_nx;

   // One step toward tgt, done in 9 bits so a carry/borrow out clamps instead of wrapping.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                              input logic [7:0] stp, input logic up);
      logic [8:0] res;
      logic [7:0] out;
      if (up) begin
         res = {1'b0, cur} + {1'b0, stp};
         out = (res[8] || (res[7:0] >= tgt)) ? tgt : res[7:0];
      end else begin
         res = {1'b0, cur} - {1'b0, stp};
         out = (res[8] || (res[7:0] <= tgt)) ? tgt : res[7:0];
      end
      return out;
   endfunction

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= IDLE;
         phinc     <= '0;
         target    <= '0;
         dir_up    <= 1'b1;
         dwell_cnt <= '0;
         lat_start <= '0;
         lat_stop  <= '0;
         lat_step  <= 8'd1;
         lat_dwell <= '0;
         lat_mode  <= 1'b0;
         done      <= 1'b0;
         acc_clrn  <= 1'b1;
      end else begin
         state     <= state_nx;
         phinc     <= phinc_nx;
         target    <= target_nx;
         dir_up    <= dir_up_nx;
         dwell_cnt <= dwell_cnt_nx;
         lat_start <= lat_start_nx;
         lat_stop  <= lat_stop_nx;
         lat_step  <= lat_step_nx;
         lat_dwell <= lat_dwell_nx;
         lat_mode  <= lat_mode_nx;
         done      <= done_nx;
         acc_clrn  <= acc_clrn_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      phinc_nx     = phinc;
      target_nx    = target;
      dir_up_nx    = dir_up;
      dwell_cnt_nx = dwell_cnt;
      lat_start_nx = lat_start;
      lat_stop_nx  = lat_stop;
      lat_step_nx  = lat_step;
      lat_dwell_nx = lat_dwell;
      lat_mode_nx  = lat_mode;
      done_nx      = 1'b0;
      acc_clrn_nx  = 1'b1;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               lat_start_nx = f_start;
               lat_stop_nx  = f_stop;
               lat_step_nx  = (f_step == 8'd0) ? 8'd1 : f_step;
               lat_dwell_nx = dwell;
               lat_mode_nx  = mode;
               phinc_nx     = f_start;
               dwell_cnt_nx = dwell;
               dir_up_nx    = (f_stop >= f_start);
               target_nx    = f_stop;
               acc_clrn_nx  = 1'b0;
               state_nx     = SWEEP;
            end
         end
         SWEEP: begin
            if (abort) begin
               state_nx = IDLE;
            end else if (dwell_cnt != '0) begin
               dwell_cnt_nx = dwell_cnt - DWELL_W'(1);
            end else begin
               dwell_cnt_nx = lat_dwell;
               if (phinc != target) begin
                  phinc_nx = step_toward(phinc, target, lat_step, dir_up);
               end else if (!lat_mode) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end else begin
                  // Reverse and step in the same expiry so the endpoint is held only one dwell.
                  dir_up_nx = !dir_up;
                  target_nx = (target == lat_stop) ? lat_start : lat_stop;
                  phinc_nx  = step_toward(phinc, target_nx, lat_step, !dir_up);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == SWEEP);

endmodule
